// File: rtl/frame_pkg.sv
// Shared types and helpers for the AXI-Stream frame tracking path.
package frame_pkg;

  typedef enum logic [1:0] {FT_IDLE, FT_HEADER, FT_PAYLOAD, FT_DROP} ft_state_e;

  localparam int unsigned ETH_MIN_LEN = 60;
  localparam int unsigned ETH_MAX_LEN = 1514;
  localparam int unsigned HDR_IDX_W   = 4;

  // Counts set bits of a byte-enable vector; callers zero-extend narrower keeps.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational tkeep -> byte count; also used by the header extractor.
module keep_popcount
  import frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned CNT_W      = $clog2(DATA_BYTES + 1)
) (
  input  logic [DATA_BYTES-1:0] tkeep,
  output logic [CNT_W-1:0]      n_bytes_c
);

  assign n_bytes_c = CNT_W'(popcount(64'(tkeep)));

endmodule

// File: rtl/frame_tracker.sv
// Beat-level Ethernet frame tracker: header counting, length accumulation,
// runt detection and truncation of oversize frames.
module frame_tracker
  import frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned HDR_BEATS  = 2,
  parameter int unsigned MIN_LEN    = ETH_MIN_LEN,
  parameter int unsigned MAX_LEN    = ETH_MAX_LEN,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + DATA_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_accept,
  input  logic                  tlast,
  input  logic [DATA_BYTES-1:0] tkeep,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  in_header,
  output logic                  in_payload,
  output logic                  in_drop,
  output logic [HDR_IDX_W-1:0]  hdr_idx,
  output logic [LEN_W-1:0]      frame_len,
  output logic                  err_runt,
  output logic                  err_oversize
);

  localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

  ft_state_e              state, state_d;
  logic [LEN_W-1:0]       byte_cnt, byte_cnt_d;
  logic [HDR_IDX_W-1:0]   hdr_idx_d;
  logic [LEN_W-1:0]       frame_len_d;
  logic                   start_d, end_d, runt_d, over_d;
  logic                   in_header_d, in_payload_d, in_drop_d;
  logic [CNT_W-1:0]       n_bytes_c;
  logic [LEN_W:0]         acc_wide;
  logic [LEN_W-1:0]       acc;

  keep_popcount #(.DATA_BYTES(DATA_BYTES), .CNT_W(CNT_W)) u_keep_popcount (
    .tkeep     (tkeep),
    .n_bytes_c (n_bytes_c)
  );

  // One guard bit so the running count pins at all-ones instead of wrapping.
  assign acc_wide = (LEN_W+1)'(byte_cnt) + (LEN_W+1)'(n_bytes_c);
  assign acc      = acc_wide[LEN_W] ? {LEN_W{1'b1}} : acc_wide[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FT_IDLE;
      byte_cnt     <= '0;
      hdr_idx      <= '0;
      frame_len    <= '0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      err_runt     <= 1'b0;
      err_oversize <= 1'b0;
      in_header    <= 1'b0;
      in_payload   <= 1'b0;
      in_drop      <= 1'b0;
    end else begin
      state        <= state_d;
      byte_cnt     <= byte_cnt_d;
      hdr_idx      <= hdr_idx_d;
      frame_len    <= frame_len_d;
      frame_start  <= start_d;
      frame_end    <= end_d;
      err_runt     <= runt_d;
      err_oversize <= over_d;
      in_header    <= in_header_d;
      in_payload   <= in_payload_d;
      in_drop      <= in_drop_d;
    end
  end

  // Next state, counters and frame-end status.
  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    hdr_idx_d   = hdr_idx;
    frame_len_d = frame_len;
    start_d     = 1'b0;
    end_d       = 1'b0;
    runt_d      = 1'b0;
    over_d      = 1'b0;
    if (beat_accept) begin
      unique case (state)
        FT_IDLE: begin
          start_d    = 1'b1;
          byte_cnt_d = LEN_W'(n_bytes_c);
          if (tlast) begin
            end_d       = 1'b1;
            frame_len_d = LEN_W'(n_bytes_c);
            runt_d      = 32'(n_bytes_c) < MIN_LEN;
            over_d      = 32'(n_bytes_c) > MAX_LEN;
          end else if (HDR_BEATS == 1) begin
            state_d = FT_PAYLOAD;
          end else begin
            state_d   = FT_HEADER;
            hdr_idx_d = HDR_IDX_W'(1);
          end
        end
        FT_HEADER: begin
          byte_cnt_d = acc;
          if (tlast) begin
            state_d     = FT_IDLE;
            hdr_idx_d   = '0;
            end_d       = 1'b1;
            frame_len_d = acc;
            runt_d      = 1'b1;
          end else if (hdr_idx == HDR_IDX_W'(HDR_BEATS - 1)) begin
            state_d   = FT_PAYLOAD;
            hdr_idx_d = '0;
          end else begin
            hdr_idx_d = HDR_IDX_W'(hdr_idx + HDR_IDX_W'(1));
          end
        end
        FT_PAYLOAD: begin
          byte_cnt_d = acc;
          if (tlast) begin
            state_d     = FT_IDLE;
            end_d       = 1'b1;
            frame_len_d = acc;
            runt_d      = 32'(acc) < MIN_LEN;
            over_d      = 32'(acc) > MAX_LEN;
          end else if (32'(acc) > MAX_LEN) begin
            state_d = FT_DROP;
          end
        end
        FT_DROP: begin
          byte_cnt_d = acc;
          if (tlast) begin
            state_d     = FT_IDLE;
            end_d       = 1'b1;
            frame_len_d = acc;
            over_d      = 1'b1;
          end
        end
      endcase
    end
  end

  // Moore status flags, registered from the next state.
  always_comb begin
    in_header_d  = 1'b0;
    in_payload_d = 1'b0;
    in_drop_d    = 1'b0;
    unique case (state_d)
      FT_HEADER:  in_header_d  = 1'b1;
      FT_PAYLOAD: in_payload_d = 1'b1;
      FT_DROP:    in_drop_d    = 1'b1;
      default:    ;
    endcase
  end

endmodule
